// File: rtl/i2s_tx_frame_pkg.sv
// Shared types and default constants for the I2S/left-justified transmitter slice.
package i2s_pkg;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } i2s_fmt_e;

  typedef enum logic {
    CG_IDLE = 1'b0,
    CG_RUN  = 1'b1
  } cg_state_e;

  localparam int DEF_DATA_W        = 24;
  localparam int DEF_SLOT_W        = 32;
  localparam int DEF_MCLK_PER_SCLK = 4;

endpackage

// File: rtl/i2s_tx_frame_if.sv
// Sample-pair valid/ready channel from the mixer/FIFO into the transmitter.
interface i2s_tx_frame_if
  import i2s_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] SAMPLE_L;
  logic [DATA_W-1:0] SAMPLE_R;
  logic              SAMPLE_VALID;
  logic              SAMPLE_READY;

  modport master (output SAMPLE_L, output SAMPLE_R, output SAMPLE_VALID, input SAMPLE_READY);
  modport slave  (input SAMPLE_L, input SAMPLE_R, input SAMPLE_VALID, output SAMPLE_READY);

endinterface

// File: rtl/i2s_tx_frame_clk_gen.sv
// SCLK/LRCLK generation from MCLK as enable ticks; ENABLE only takes effect at a frame boundary.
//  state   | meaning
//  CG_IDLE | serial clocks stopped, counters held at 0; every MCLK is a frame boundary
//  CG_RUN  | div_cnt/bit_pos running; boundary is the fall_tick that wraps bit_pos
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SLOT_W        = DEF_SLOT_W,
  parameter int MCLK_PER_SCLK = DEF_MCLK_PER_SCLK
) (
  input  logic MCLK,
  input  logic RESET_N,
  input  logic ENABLE,
  output logic SCLK,
  output logic LRCLK,
  output logic fall_tick,
  output logic frame_tick,
  output logic stop_tick
);

  localparam int DW = $clog2(MCLK_PER_SCLK);
  localparam int BW = $clog2(2 * SLOT_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(MCLK_PER_SCLK - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_PER_SCLK / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(SLOT_W);

  cg_state_e         state;
  logic [DW-1:0]     div_cnt;
  logic [DW-1:0]     div_nxt;
  logic [BW-1:0]     bit_pos;
  logic [BW-1:0]     bit_nxt;
  logic              boundary;

  always_comb begin
    fall_tick  = (state == CG_RUN) && (div_cnt == DIV_LAST);
    boundary   = (state == CG_IDLE) || (fall_tick && (bit_pos == BIT_LAST));
    frame_tick = boundary && ENABLE;
    stop_tick  = boundary && !ENABLE && (state == CG_RUN);
    div_nxt    = ((state == CG_IDLE) || fall_tick) ? '0 : div_cnt + DW'(1);
    bit_nxt    = boundary ? '0 : (fall_tick ? bit_pos + BW'(1) : bit_pos);
  end

  // SCLK/LRCLK are decoded from next-state counts so they move on the same edge as the counters
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= CG_IDLE;
      div_cnt <= '0;
      bit_pos <= '0;
      SCLK    <= 1'b0;
      LRCLK   <= 1'b0;
    end else begin
      if (boundary) begin
        state <= ENABLE ? CG_RUN : CG_IDLE;
      end
      div_cnt <= div_nxt;
      bit_pos <= bit_nxt;
      SCLK    <= (div_nxt >= DIV_HALF);
      LRCLK   <= (bit_nxt >= BIT_HALF);
    end
  end

endmodule

// File: rtl/i2s_tx_frame.sv
// Stereo I2S / left-justified serial transmitter: one-deep shadow buffer, frame shifter, underrun flag.
module i2s_tx_frame
  import i2s_pkg::*;
#(
  parameter int       DATA_W        = DEF_DATA_W,
  parameter int       SLOT_W        = DEF_SLOT_W,
  parameter int       MCLK_PER_SCLK = DEF_MCLK_PER_SCLK,
  parameter i2s_fmt_e FORMAT        = FMT_I2S
) (
  input  logic           MCLK,
  input  logic           RESET_N,
  input  logic           ENABLE,
  i2s_tx_frame_if.slave  smp,
  output logic           SCLK,
  output logic           LRCLK,
  output logic           SDOUT,
  output logic           FRAME_START,
  output logic           UNDERRUN
);

  if ((DATA_W < 1) || (DATA_W > SLOT_W) || (MCLK_PER_SCLK < 2) || ((MCLK_PER_SCLK % 2) != 0))
  begin : g_param_err
    $error("i2s_tx_frame: illegal DATA_W/SLOT_W/MCLK_PER_SCLK combination");
  end

  localparam int FW = 2 * SLOT_W;

  logic              fall_tick;
  logic              frame_tick;
  logic              stop_tick;
  logic              shadow_full;
  logic              xfer;
  logic [DATA_W-1:0] shadow_l;
  logic [DATA_W-1:0] shadow_r;
  logic [FW-1:0]     frame_new;
  logic [FW-1:0]     frame_sr;

  i2s_clk_gen #(
    .SLOT_W        (SLOT_W),
    .MCLK_PER_SCLK (MCLK_PER_SCLK)
  ) u_clk_gen (
    .MCLK       (MCLK),
    .RESET_N    (RESET_N),
    .ENABLE     (ENABLE),
    .SCLK       (SCLK),
    .LRCLK      (LRCLK),
    .fall_tick  (fall_tick),
    .frame_tick (frame_tick),
    .stop_tick  (stop_tick)
  );

  assign smp.SAMPLE_READY = !shadow_full;
  assign xfer             = smp.SAMPLE_VALID && !shadow_full;

  // Empty shadow at load time yields a muted frame
  always_comb begin
    frame_new = '0;
    if (shadow_full) begin
      frame_new[FW-1 -: DATA_W]     = shadow_l;
      frame_new[SLOT_W-1 -: DATA_W] = shadow_r;
    end
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shadow_full <= 1'b0;
      shadow_l    <= '0;
      shadow_r    <= '0;
      frame_sr    <= '0;
      SDOUT       <= 1'b0;
      FRAME_START <= 1'b0;
      UNDERRUN    <= 1'b0;
    end else begin
      FRAME_START <= frame_tick;
      UNDERRUN    <= frame_tick && !shadow_full;
      shadow_full <= xfer || (shadow_full && !frame_tick);
      if (xfer) begin
        shadow_l <= smp.SAMPLE_L;
        shadow_r <= smp.SAMPLE_R;
      end
      if (stop_tick) begin
        frame_sr <= '0;
        SDOUT    <= 1'b0;
      end else if (frame_tick) begin
        // I2S emits the previous frame's last bit during bit_pos 0
        if (FORMAT == FMT_LJ) begin
          SDOUT    <= frame_new[FW-1];
          frame_sr <= frame_new << 1;
        end else begin
          SDOUT    <= frame_sr[FW-1];
          frame_sr <= frame_new;
        end
      end else if (fall_tick) begin
        SDOUT    <= frame_sr[FW-1];
        frame_sr <= frame_sr << 1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_frame.sv
// Directed checks of i2s_tx_frame: defaults in I2S mode plus a 16/16 left-justified instance.
module tb_i2s_tx_frame;
  import i2s_pkg::*;

  logic MCLK;
  logic RESET_N;
  logic en_m;
  logic en_l;
  logic sclk, lrclk, sdout, fs, ur;
  logic l_sclk, l_lrclk, l_sdout, l_fs, l_ur;

  int comps;
  int fails;

  i2s_tx_frame_if #(.DATA_W(24)) m_if ();
  i2s_tx_frame_if #(.DATA_W(16)) l_if ();

  i2s_tx_frame u_dut (
    .MCLK        (MCLK),
    .RESET_N     (RESET_N),
    .ENABLE      (en_m),
    .smp         (m_if.slave),
    .SCLK        (sclk),
    .LRCLK       (lrclk),
    .SDOUT       (sdout),
    .FRAME_START (fs),
    .UNDERRUN    (ur)
  );

  i2s_tx_frame #(
    .DATA_W        (16),
    .SLOT_W        (16),
    .MCLK_PER_SCLK (4),
    .FORMAT        (FMT_LJ)
  ) u_lj (
    .MCLK        (MCLK),
    .RESET_N     (RESET_N),
    .ENABLE      (en_l),
    .smp         (l_if.slave),
    .SCLK        (l_sclk),
    .LRCLK       (l_lrclk),
    .SDOUT       (l_sdout),
    .FRAME_START (l_fs),
    .UNDERRUN    (l_ur)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    comps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fs_main();
    for (int k = 0; k < 16 && !fs; k++) @(negedge MCLK);
    chk("frame_start_seen", 64'(fs), 64'd1);
  endtask

  // One 256-MCLK frame starting at the FRAME_START cycle; ends on the next frame's first cycle
  task automatic cap_main(input bit keep_valid, output logic [63:0] sd, output logic [63:0] lr,
                          output int sclk_hi, output int sclk_rise, output int lr_hi,
                          output int xfers);
    logic prev;
    sd = '0; lr = '0; sclk_hi = 0; sclk_rise = 0; lr_hi = 0; xfers = 0;
    prev = sclk;
    for (int i = 0; i < 256; i++) begin
      if (m_if.SAMPLE_VALID && m_if.SAMPLE_READY) xfers++;
      if ((i % 4) == 2) begin
        sd[63 - i/4] = sdout;
        lr[63 - i/4] = lrclk;
      end
      if (sclk) sclk_hi++;
      if (sclk && !prev) sclk_rise++;
      if (lrclk) lr_hi++;
      prev = sclk;
      @(negedge MCLK);
      if (!keep_valid && !m_if.SAMPLE_READY) m_if.SAMPLE_VALID = 1'b0;
    end
  endtask

  logic [63:0] sd, lr;
  logic [31:0] lj_sd;
  int          s_hi, s_rise, l_hi, nx;

  initial begin
    comps = 0;
    fails = 0;
    RESET_N = 1'b0;
    en_m = 1'b0;
    en_l = 1'b0;
    m_if.SAMPLE_VALID = 1'b0;
    m_if.SAMPLE_L = '0;
    m_if.SAMPLE_R = '0;
    l_if.SAMPLE_VALID = 1'b0;
    l_if.SAMPLE_L = '0;
    l_if.SAMPLE_R = '0;
    repeat (2) @(negedge MCLK);
    chk("reset_outputs", 64'({sclk, lrclk, sdout, fs, ur, m_if.SAMPLE_READY}), 64'b000001);
    RESET_N = 1'b1;
    @(negedge MCLK);

    // Pair A captured while disabled; shadow holds it, nothing toggles
    m_if.SAMPLE_L = 24'h800001;
    m_if.SAMPLE_R = 24'h7FFFFE;
    m_if.SAMPLE_VALID = 1'b1;
    @(negedge MCLK);
    m_if.SAMPLE_VALID = 1'b0;
    repeat (4) @(negedge MCLK);
    chk("disabled_idle", 64'({sclk, lrclk, sdout, fs, ur, m_if.SAMPLE_READY}), 64'b000000);

    en_m = 1'b1;
    wait_fs_main();
    chk("f1_no_underrun", 64'(ur), 64'd0);
    cap_main(1'b0, sd, lr, s_hi, s_rise, l_hi, nx);
    chk("f1_i2s_data", sd, 64'h40000080_3FFFFF00);
    chk("f1_lrclk_slots", lr, 64'h00000000_FFFFFFFF);
    chk("sclk_high_mclks", 64'(s_hi), 64'd128);
    chk("sclk_rises_per_frame", 64'(s_rise), 64'd64);
    chk("lrclk_high_mclks", 64'(l_hi), 64'd128);

    // Frame 2: nothing was offered during frame 1 -> muted underrun frame; pair B arrives now
    chk("f2_start_256", 64'({fs, ur}), 64'b11);
    m_if.SAMPLE_L = 24'h123456;
    m_if.SAMPLE_R = 24'hABCDEF;
    m_if.SAMPLE_VALID = 1'b1;
    cap_main(1'b0, sd, lr, s_hi, s_rise, l_hi, nx);
    chk("f2_muted_data", sd, 64'd0);
    chk("f2_one_xfer", 64'(nx), 64'd1);

    // Frame 3 carries B; VALID then stays high with pair C
    chk("f3_start", 64'({fs, ur}), 64'b10);
    m_if.SAMPLE_L = 24'hFFFFFF;
    m_if.SAMPLE_R = 24'h000001;
    m_if.SAMPLE_VALID = 1'b1;
    cap_main(1'b1, sd, lr, s_hi, s_rise, l_hi, nx);
    chk("f3_i2s_data", sd, 64'h091A2B00_55E6F780);
    chk("f3_one_xfer", 64'(nx), 64'd1);

    chk("f4_start", 64'({fs, ur}), 64'b10);
    cap_main(1'b1, sd, lr, s_hi, s_rise, l_hi, nx);
    chk("f4_i2s_data", sd, 64'h7FFFFF80_00000080);
    chk("f4_one_xfer", 64'(nx), 64'd1);

    // Frame 5: ENABLE drops mid-frame, frame runs to its end and then clocks stop
    chk("f5_start", 64'({fs, ur}), 64'b10);
    for (int i = 0; i < 256; i++) begin
      if (i == 100) en_m = 1'b0;
      if (i == 255) chk("f5_completes", 64'({sclk, lrclk}), 64'b11);
      @(negedge MCLK);
    end
    chk("stopped_after_frame", 64'({fs, ur, sclk, lrclk, sdout}), 64'b00000);
    s_hi = 0;
    nx = 0;
    for (int i = 0; i < 40; i++) begin
      if (sclk || lrclk) s_hi++;
      if (fs || ur) nx++;
      @(negedge MCLK);
    end
    chk("stopped_clocks_quiet", 64'(s_hi), 64'd0);
    chk("stopped_no_pulses", 64'(nx), 64'd0);

    // Mid-frame reset while SCLK and LRCLK are both high
    en_m = 1'b1;
    wait_fs_main();
    for (int i = 0; i < 150; i++) @(negedge MCLK);
    chk("pre_reset", 64'({sclk, lrclk, m_if.SAMPLE_READY}), 64'b110);
    #2 RESET_N = 1'b0;
    #1 chk("async_reset", 64'({sclk, lrclk, sdout, fs, ur, m_if.SAMPLE_READY}), 64'b000001);
    @(negedge MCLK);
    RESET_N = 1'b1;
    wait_fs_main();
    chk("post_reset_underrun", 64'(ur), 64'd1);
    s_rise = 0;
    l_hi = 0;
    for (int i = 0; i < 128; i++) begin
      if (i == 2) s_rise = sclk ? 1 : 0;
      if (lrclk) l_hi++;
      @(negedge MCLK);
    end
    chk("post_reset_sclk_phase", 64'(s_rise), 64'd1);
    chk("post_reset_left_slot", 64'({l_hi[7:0], lrclk}), 64'({8'd0, 1'b1}));
    m_if.SAMPLE_VALID = 1'b0;
    en_m = 1'b0;

    // Left-justified 16/16 instance
    l_if.SAMPLE_L = 16'hA5A5;
    l_if.SAMPLE_R = 16'h8F0F;
    l_if.SAMPLE_VALID = 1'b1;
    @(negedge MCLK);
    l_if.SAMPLE_VALID = 1'b0;
    en_l = 1'b1;
    for (int k = 0; k < 16 && !l_fs; k++) @(negedge MCLK);
    chk("lj_frame_start_seen", 64'({l_fs, l_ur}), 64'b10);
    chk("lj_msb_at_lr_edge", 64'({l_lrclk, l_sdout}), 64'b01);
    lj_sd = '0;
    for (int i = 0; i < 128; i++) begin
      if ((i % 4) == 2) lj_sd[31 - i/4] = l_sdout;
      if (i == 63) chk("lj_left_end", 64'(l_lrclk), 64'd0);
      if (i == 64) chk("lj_right_msb_at_edge", 64'({l_lrclk, l_sdout}), 64'b11);
      @(negedge MCLK);
    end
    chk("lj_data", 64'(lj_sd), 64'h00000000_A5A58F0F);
    chk("lj_next_underrun", 64'({l_fs, l_ur}), 64'b11);
    en_l = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
